load_store_unit: RTL

Memory-access stage sitting directly downstream of the ALU in the RISC-V core. Consumes the ALU result as the effective address and the second register operand as store data. Performs byte/half/word loads and stores over a simple req/ack data bus, and stalls the single-cycle datapath until the access completes. Returns the formatted, sign- or zero-extended load value to the writeback mux.

---
 rtl/load_store_unit_if.sv | 20 ++
 rtl/load_store_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Request/acknowledge data-bus bundle between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: byte/half/word loads and stores over a req/ack bus.
// Stalls the datapath until the access completes or times out.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] rd_final2,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        lsu_fault,
  output logic        bus_timeout,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_be_q;
  logic [31:0] load_data_q;
  logic        bus_timeout_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;

  logic        has_req;
  logic        f3_ok;
  logic        misaligned;
  logic        req_fault;
  logic [1:0]  lane;
  logic [31:0] wdata_d;
  logic [3:0]  be_d;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_fmt_d;

  always_comb begin
    lane       = alu_result[1:0];
    has_req    = mem_read | mem_write;
    // mem_write takes priority, so store legality applies when both are set
    f3_ok      = mem_write ? (funct3 inside {3'b000, 3'b001, 3'b010})
                           : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = ((funct3[1:0] == 2'b01) & alu_result[0]) |
                 ((funct3[1:0] == 2'b10) & (|alu_result[1:0]));
    req_fault  = has_req & (~f3_ok | misaligned);

    wdata_d = '0;
    be_d    = 4'b1111;
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: begin
          wdata_d = {4{rd_final2[7:0]}};
          be_d    = 4'b0001 << lane;
        end
        2'b01: begin
          wdata_d = {2{rd_final2[15:0]}};
          be_d    = lane[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata_d = rd_final2;
          be_d    = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    case (lane_q)
      2'd0:    rbyte = bus.bus_rdata[7:0];
      2'd1:    rbyte = bus.bus_rdata[15:8];
      2'd2:    rbyte = bus.bus_rdata[23:16];
      default: rbyte = bus.bus_rdata[31:24];
    endcase
    rhalf = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (funct3_q)
      3'b000:  load_fmt_d = {{24{rbyte[7]}}, rbyte};
      3'b100:  load_fmt_d = {24'd0, rbyte};
      3'b001:  load_fmt_d = {{16{rhalf[15]}}, rhalf};
      3'b101:  load_fmt_d = {16'd0, rhalf};
      default: load_fmt_d = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      bus_be_q      <= '0;
      load_data_q   <= '0;
      bus_timeout_q <= 1'b0;
      funct3_q      <= '0;
      lane_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          bus_timeout_q <= 1'b0;
          if (has_req && !req_fault) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_write;
            bus_addr_q  <= {alu_result[31:2], 2'b00};
            bus_wdata_q <= wdata_d;
            bus_be_q    <= be_d;
            funct3_q    <= funct3;
            lane_q      <= lane;
            cnt_q       <= '0;
            state_q     <= REQ;
          end
        end
        REQ: begin
          // an ack on the final wait cycle wins over the timeout
          if (bus.bus_ack) begin
            bus_req_q <= 1'b0;
            if (!bus_we_q) load_data_q <= load_fmt_d;
            state_q   <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            bus_req_q     <= 1'b0;
            if (!bus_we_q) load_data_q <= '0;
            bus_timeout_q <= 1'b1;
            state_q       <= DONE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DONE: begin
          bus_timeout_q <= 1'b0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall         = (state_q == REQ) | ((state_q == IDLE) & has_req & ~req_fault);
  assign lsu_fault     = (state_q == IDLE) & req_fault;
  assign load_data     = load_data_q;
  assign bus_timeout   = bus_timeout_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_be    = bus_be_q;

endmodule
